// File: rtl/shifter_pkg.sv
// Shared types and encodings for the iterative shifter (SHIFTER_ROTATE_EN enables rotation in iter_shifter).
package shifter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic SH_LEFT  = 1'b1;
    localparam logic SH_RIGHT = 1'b0;
    localparam logic SH_ARITH = 1'b1;
    localparam logic SH_LOGIC = 1'b0;

endpackage

// File: rtl/iter_shifter_shift_step.sv
// Combinational single-position shift/rotate stage used once per clock by iter_shifter.
module shift_step
    import shifter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] d,
    input  logic             lr,
    input  logic             al,
    input  logic             rot,
    output logic [WIDTH-1:0] q
);

    always_comb begin
        q = d;
        if (lr == SH_LEFT) begin
            q = {d[WIDTH-2:0], rot ? d[WIDTH-1] : 1'b0};
        end else if (rot) begin
            q = {d[0], d[WIDTH-1:1]};
        end else if (al == SH_ARITH) begin
            q = {d[WIDTH-1], d[WIDTH-1:1]};
        end else begin
            q = {1'b0, d[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/iter_shifter.sv
// Multi-cycle shifter: one bit position per clock, valid/ready on both sides.
// Define SHIFTER_ROTATE_EN to add the rot input and rotate operations.
//
//  state | meaning
//  IDLE  | waiting for an operand, in_ready high
//  SHIFT | shifting dout one position per cycle, count = positions left
//  DONE  | result presented on dout with out_valid until out_ready
module iter_shifter
    import shifter_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] din,
    input  logic [SHW-1:0]   shamt,
    input  logic             LR,
    input  logic             AL,
`ifdef SHIFTER_ROTATE_EN
    input  logic             rot,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dout,
    output logic             busy
);

    state_t           state, state_nxt;
    logic [SHW-1:0]   count;
    logic             lr_q, al_q, rot_q;
    logic [WIDTH-1:0] stepped;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = (shamt == '0) ? DONE : SHIFT;
            SHIFT:   if (count == SHW'(1)) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout  <= '0;
            count <= '0;
            lr_q  <= SH_RIGHT;
            al_q  <= SH_LOGIC;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    dout  <= din;
                    count <= shamt;
                    lr_q  <= LR;
                    al_q  <= AL;
                end
                SHIFT: begin
                    dout  <= stepped;
                    count <= count - SHW'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef SHIFTER_ROTATE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         rot_q <= 1'b0;
        else if (state == IDLE && in_valid) rot_q <= rot;
    end
`else
    assign rot_q = 1'b0;
`endif

    shift_step #(.WIDTH(WIDTH)) u_step (
        .d   (dout),
        .lr  (lr_q),
        .al  (al_q),
        .rot (rot_q),
        .q   (stepped)
    );

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);

endmodule
